data_mem_ws: RTL and testbench

DATA_MEM_WS -- requirements
Module: data_mem_ws

---
 rtl/data_mem_ws.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_ws.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ws.sv
// Word-organised data memory with byte/halfword/word access and WAIT_CYCLES wait states.
// Optional macro DATA_MEM_INIT_SQUARES_EN presets word i to i*i at time zero.
module data_mem_ws #(
  parameter int DEPTH_LOG2  = 5,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  output logic        resp_valid,
  output logic [31:0] dataout,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef logic [31:0] mem_t [DEPTH];

  function automatic logic access_fault(input logic [1:0] sz, input logic [1:0] a);
    logic f;
    case (sz)
      2'b00:   f = 1'b0;
      2'b01:   f = a[0];
      2'b10:   f = (a != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic u, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = {{24{~u & b[7]}}, b};
      2'b01:   r = {{16{~u & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef DATA_MEM_INIT_SQUARES_EN
  function automatic mem_t squares();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = 32'(i * i);
    end
    return m;
  endfunction

  mem_t mem_q = squares();
`else
  mem_t mem_q;
`endif

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          req_ready_q, resp_valid_q, err_q;
  logic [31:0]   dataout_q;

  logic          idle_s, accept_s, enter_resp_s, wr_en_s;
  logic          cur_we_s, cur_uns_s, cur_err_s;
  logic [1:0]    cur_size_s;
  logic [AW-1:0] cur_addr_s;
  logic [31:0]   cur_data_s, rd_word_s, load_s, wr_data_s;
  logic [3:0]    wr_mask_s;
  logic [DEPTH_LOG2-1:0] cur_idx_s;
  logic          unused_addr_s;

  assign idle_s   = (state_q == S_IDLE);
  assign accept_s = idle_s & req_valid;

  // With zero wait states RESP is entered on the accepting edge, so the live inputs are the request.
  assign cur_we_s   = idle_s ? we                 : we_q;
  assign cur_size_s = idle_s ? size               : size_q;
  assign cur_uns_s  = idle_s ? uns                : uns_q;
  assign cur_addr_s = idle_s ? addr[AW-1:0]       : addr_q;
  assign cur_data_s = idle_s ? datain             : data_q;
  assign cur_idx_s  = cur_addr_s[AW-1:2];
  assign cur_err_s  = access_fault(cur_size_s, cur_addr_s[1:0]);

  assign rd_word_s  = mem_q[cur_idx_s];
  assign load_s     = load_extract(rd_word_s, cur_size_s, cur_uns_s, cur_addr_s[1:0]);
  assign wr_mask_s  = lane_mask(cur_size_s, cur_addr_s[1:0]);
  assign wr_data_s  = store_lanes(cur_size_s, cur_data_s);
  assign wr_en_s    = Resetn & enter_resp_s & cur_we_s & ~cur_err_s;

  assign unused_addr_s = ^addr[31:AW];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            state_d      = S_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      dataout_q    <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == S_IDLE);
      resp_valid_q <= enter_resp_s;
      err_q        <= enter_resp_s & cur_err_s;
      dataout_q    <= (enter_resp_s && !cur_we_s && !cur_err_s) ? load_s : 32'd0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      we_q   <= 1'b0;
      size_q <= 2'b00;
      uns_q  <= 1'b0;
      addr_q <= '0;
      data_q <= 32'd0;
    end else if (accept_s) begin
      we_q   <= we;
      size_q <= size;
      uns_q  <= uns;
      addr_q <= addr[AW-1:0];
      data_q <= datain;
    end
  end

  // Array has no reset so contents survive Resetn.
  always_ff @(posedge Clock) begin
    if (wr_en_s) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_mask_s[l]) begin
          mem_q[cur_idx_s][8*l +: 8] <= wr_data_s[8*l +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign dataout    = dataout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboard bench for data_mem_ws; preloads the words it reads with i*i so it does not
// depend on the DATA_MEM_INIT_SQUARES_EN build option.
module tb_data_mem_ws;

  localparam int WAIT_CYCLES = 1;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] datain = 32'd0;
  logic        req_ready, resp_valid, err;
  logic [31:0] dataout;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 Clock = ~Clock;

  data_mem_ws #(.DEPTH_LOG2(5), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .Clock(Clock), .Resetn(Resetn), .req_valid(req_valid), .req_ready(req_ready),
    .we(we), .size(size), .uns(uns), .addr(addr), .datain(datain),
    .resp_valid(resp_valid), .dataout(dataout), .err(err)
  );

  task automatic drive_req(input logic w, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
    we = w; size = s; uns = u; addr = a; datain = d; req_valid = 1'b1;
  endtask

  task automatic pop_compare(input string name);
    exp_t e;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: unexpected response data=%h err=%b", name, dataout, err);
    end else begin
      e = sb_q.pop_front();
      if (dataout !== e.data || err !== e.err) begin
        tests_failed++;
        $display("FAIL %s: got data=%h err=%b, expected data=%h err=%b",
                 name, dataout, err, e.data, e.err);
      end
    end
  endtask

  task automatic run_txn(input string name, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e);
    int lat;
    @(negedge Clock);
    drive_req(w, s, u, a, d);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ready: got %b expected 1", name, req_ready);
    end
    sb_q.push_back(exp_t'{data: exp_d, err: exp_e});
    @(posedge Clock);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge Clock);
      lat++;
      if (resp_valid === 1'b1) break;
    end
    if (resp_valid !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: no resp_valid within %0d cycles", name, lat);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      pop_compare(name);
      tests_run++;
      if (lat != WAIT_CYCLES + 1) begin
        tests_failed++;
        $display("FAIL %s_latency: got %0d expected %0d", name, lat, WAIT_CYCLES + 1);
      end
      @(negedge Clock);
      tests_run++;
      if (resp_valid !== 1'b0 || dataout !== 32'd0 || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_idle: got valid=%b data=%h err=%b expected 0/0/0",
                 name, resp_valid, dataout, err);
      end
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dataout !== 32'd0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b valid=%b data=%h err=%b expected 1/0/0/0",
               req_ready, resp_valid, dataout, err);
    end
    Resetn = 1'b1;
  endtask

  task automatic test_preload();
    int idx [5] = '{0, 1, 3, 4, 8};
    for (int i = 0; i < 5; i++) begin
      run_txn("preload_store", 1'b1, 2'b10, 1'b0, 32'(idx[i] * 4), 32'(idx[i] * idx[i]),
              32'd0, 1'b0);
    end
  endtask

  task automatic test_load_word();
    run_txn("load_word_0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 32'h0000_0009, 1'b0);
  endtask

  task automatic test_byte_access();
    run_txn("store_byte_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 32'd0, 1'b0);
    run_txn("load_word_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'h0000_AB10, 1'b0);
    run_txn("load_byte_sext", 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 32'hFFFF_FFAB, 1'b0);
    run_txn("load_byte_zext", 1'b0, 2'b00, 1'b1, 32'h11, 32'd0, 32'h0000_00AB, 1'b0);
  endtask

  task automatic test_half_access();
    run_txn("store_half_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 32'd0, 1'b0);
    run_txn("load_word_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hBEEF_AB10, 1'b0);
    run_txn("load_half_sext", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFF_BEEF, 1'b0);
    run_txn("load_half_zext", 1'b0, 2'b01, 1'b1, 32'h10, 32'd0, 32'h0000_AB10, 1'b0);
  endtask

  task automatic test_errors();
    run_txn("store_word_misal", 1'b1, 2'b10, 1'b0, 32'h06, 32'hDEAD_BEEF, 32'd0, 1'b1);
    run_txn("load_word_04", 1'b0, 2'b10, 1'b0, 32'h04, 32'd0, 32'h0000_0001, 1'b0);
    run_txn("store_half_misal", 1'b1, 2'b01, 1'b0, 32'h13, 32'h0000_7777, 32'd0, 1'b1);
    run_txn("size_reserved", 1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
    run_txn("load_word_10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hBEEF_AB10, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge Clock);
    drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0055);
    @(posedge Clock);
    #1 req_valid = 1'b0;
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got ready=%b valid=%b expected 1/0", req_ready, resp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      if (resp_valid !== 1'b0) seen++;
    end
    Resetn = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      if (resp_valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_noresp: got %0d response cycles expected 0", seen);
    end
    run_txn("load_word_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h0000_0040, 1'b0);
  endtask

  task automatic test_wrap();
    run_txn("load_word_80_wrap", 1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 32'h0000_0000, 1'b0);
    run_txn("load_word_8c_wrap", 1'b0, 2'b10, 1'b0, 32'h8C, 32'd0, 32'h0000_0009, 1'b0);
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int drain;
    @(negedge Clock);
    drive_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0);
    for (int c = 0; c < 12; c++) begin
      if (req_ready === 1'b1) begin
        accepts.push_back(c);
        sb_q.push_back(exp_t'{data: 32'h0000_0009, err: 1'b0});
      end
      @(negedge Clock);
      if (resp_valid === 1'b1) pop_compare("b2b_resp");
    end
    req_valid = 1'b0;
    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(negedge Clock);
      drain++;
      if (resp_valid === 1'b1) pop_compare("b2b_drain");
    end
    tests_run++;
    if (accepts.size() != 4 || sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d accepts, %0d pending, expected 4 accepts, 0 pending",
               accepts.size(), sb_q.size());
    end
    for (int i = 1; i < accepts.size(); i++) begin
      tests_run++;
      if (accepts[i] - accepts[i-1] != 3) begin
        tests_failed++;
        $display("FAIL b2b_spacing: got %0d cycles expected 3", accepts[i] - accepts[i-1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_preload();
    test_load_word();
    test_byte_access();
    test_half_access();
    test_errors();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
